// File: rtl/microarchi_sc_pkg.sv
// Shared encodings for the single-cycle RV32I core: opcodes, funct3 values,
// ALU operations and the write-back source select.
package microarchi_sc_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {WB_ALU, WB_IMM, WB_PC4, WB_LOAD} wb_sel_e;

  // alt selects SUB/SRA over ADD/SRL; callers only raise it where legal.
  function automatic alu_op_e f3_alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/microarchi_sc_alu.sv
// Combinational RV32I ALU; the zero flag drives branch resolution.
module microarchi_sc_alu
  import microarchi_sc_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/microarchi_sc.sv
// Single-cycle RV32I core with on-chip IMEM/DMEM; IMEM is filled through the
// load port while reset is held low, execution starts at address 0.
module microarchi_sc
  import microarchi_sc_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input logic        clk,
  input logic        rst,
  input logic [31:0] LoadProg_addr,
  input logic [31:0] LoadProg_data
);

  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_WORDS);

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] rf   [32];
  logic [31:0] pc;

  logic [31:0] instr, rs1_val, rs2_val, pc_plus4;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  assign instr  = imem[pc[IA+1:2]];
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Combinational reads see the pre-edge value, so read-during-write returns old data.
  assign rs1_val  = (rs1 == '0) ? '0 : rf[rs1];
  assign rs2_val  = (rs2 == '0) ? '0 : rf[rs2];
  assign pc_plus4 = pc + 32'd4;

  logic imm_ok, reg_ok;
  assign imm_ok = (funct3 == F3_SLL) ? (funct7 == 7'h00)
                : (funct3 == F3_SR)  ? (funct7 == 7'h00 || funct7 == 7'h20)
                : 1'b1;
  assign reg_ok = (funct7 == 7'h00) ||
                  (funct7 == 7'h20 && (funct3 == F3_ADD || funct3 == F3_SR));

  alu_op_e     alu_op;
  wb_sel_e     wb_sel;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        alu_zero, reg_we, mem_we, is_branch, is_jal, is_jalr;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    alu_op    = ALU_ADD;
    alu_a     = rs1_val;
    alu_b     = imm_i;
    wb_sel    = WB_ALU;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OP_LUI: begin
        reg_we = 1'b1;
        wb_sel = WB_IMM;
      end
      OP_AUIPC: begin
        alu_a  = pc;
        alu_b  = imm_u;
        reg_we = 1'b1;
      end
      OP_JAL: begin
        reg_we = 1'b1;
        wb_sel = WB_PC4;
        is_jal = 1'b1;
      end
      OP_JALR: if (funct3 == 3'b000) begin
        reg_we  = 1'b1;
        wb_sel  = WB_PC4;
        is_jalr = 1'b1;
      end
      OP_BRANCH: begin
        alu_b     = rs2_val;
        is_branch = (funct3[2:1] != 2'b01);
        alu_op    = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
      end
      OP_LOAD: if (funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}) begin
        reg_we = 1'b1;
        wb_sel = WB_LOAD;
      end
      OP_STORE: begin
        alu_b  = imm_s;
        mem_we = (funct3 inside {F3_SB, F3_SH, F3_SW});
      end
      OP_IMM: begin
        alu_op = f3_alu_op(funct3, funct3 == F3_SR && funct7[5]);
        reg_we = imm_ok;
      end
      OP_REG: begin
        alu_b  = rs2_val;
        alu_op = f3_alu_op(funct3, funct7[5]);
        reg_we = reg_ok;
      end
      default: ;
    endcase
  end

  microarchi_sc_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_res),
    .zero   (alu_zero)
  );

  // Even funct3 codes (BEQ/BLT/BLTU) take when the compare is non-zero except BEQ; parity of bits 2 and 0 sorts it.
  logic        branch_taken;
  logic [31:0] next_pc;
  assign branch_taken = is_branch && (alu_zero == (funct3[2] == funct3[0]));

  always_comb begin
    next_pc = pc_plus4;
    if (is_jalr)                     next_pc = {alu_res[31:1], 1'b0};
    else if (is_jal)                 next_pc = pc + imm_j;
    else if (branch_taken)           next_pc = pc + imm_b;
  end

  logic [31:0] dmem_word, load_data, wb_data, store_data;
  logic [15:0] lane_half;
  logic [7:0]  lane_byte;
  logic [3:0]  store_be;

  assign dmem_word = dmem[alu_res[DA+1:2]];
  assign lane_byte = dmem_word[{alu_res[1:0], 3'b000} +: 8];
  assign lane_half = alu_res[1] ? dmem_word[31:16] : dmem_word[15:0];

  always_comb begin
    load_data = dmem_word;
    case (funct3)
      F3_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      F3_LBU:  load_data = {24'b0, lane_byte};
      F3_LHU:  load_data = {16'b0, lane_half};
      default: load_data = dmem_word;
    endcase
  end

  always_comb begin
    store_be   = '0;
    store_data = rs2_val;
    case (funct3)
      F3_SB: begin
        store_be   = 4'b0001 << alu_res[1:0];
        store_data = {4{rs2_val[7:0]}};
      end
      F3_SH: begin
        store_be   = alu_res[1] ? 4'b1100 : 4'b0011;
        store_data = {2{rs2_val[15:0]}};
      end
      F3_SW:   store_be = 4'b1111;
      default: store_be = '0;
    endcase
  end

  always_comb begin
    case (wb_sel)
      WB_IMM:  wb_data = imm_u;
      WB_PC4:  wb_data = pc_plus4;
      WB_LOAD: wb_data = load_data;
      default: wb_data = alu_res;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst) pc <= '0;
    else      pc <= next_pc;
  end

  // NOTE: only the register file is reset; IMEM and DMEM are plain RAMs with no reset path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (reg_we && rd != '0) begin
      rf[rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) imem[LoadProg_addr[IA+1:2]] <= LoadProg_data;
  end

  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      for (int i = 0; i < 4; i++)
        if (store_be[i]) dmem[alu_res[DA+1:2]][i*8 +: 8] <= store_data[i*8 +: 8];
    end
  end

  logic unused_load_addr;
  assign unused_load_addr = ^{LoadProg_addr[31:IA+2], LoadProg_addr[1:0]};

endmodule

// File: tb/tb_microarchi_sc.sv
// Directed programs for microarchi_sc, checked every cycle against an
// instruction-level model plus hand-computed architectural results.
module tb_microarchi_sc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] LoadProg_addr = '0;
  logic [31:0] LoadProg_data = '0;

  always #5 clk = ~clk;

  microarchi_sc dut (
    .clk           (clk),
    .rst           (rst),
    .LoadProg_addr (LoadProg_addr),
    .LoadProg_data (LoadProg_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Architectural model: byte-addressed data memory, plain ISA semantics.
  logic [31:0] m_pc;
  logic [31:0] m_regs [32];
  logic [31:0] m_imem [256];
  logic [7:0]  m_dmem [1024];
  bit          m_dv   [1024];
  bit          chk_en = 1'b0;

  task automatic model_reset();
    m_pc = '0;
    foreach (m_regs[i]) m_regs[i] = '0;
  endtask

  task automatic model_step();
    logic [31:0] ins, a, b, ii, is, ib, iu, ij, npc, val, addr;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        wr, t;
    int          wb, hb;
    ins = m_imem[m_pc[9:2]];
    op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; f7 = ins[31:25];
    a  = m_regs[ins[19:15]];
    b  = m_regs[ins[24:20]];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iu = {ins[31:12], 12'b0};
    ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    npc = m_pc + 32'd4; wr = 1'b0; val = '0; t = 1'b0;
    case (op)
      7'h37: begin wr = 1; val = iu; end
      7'h17: begin wr = 1; val = m_pc + iu; end
      7'h6F: begin wr = 1; val = m_pc + 4; npc = m_pc + ij; end
      7'h67: if (f3 == 0) begin wr = 1; val = m_pc + 4; npc = (a + ii) & ~32'd1; end
      7'h63: begin
        case (f3)
          0: t = (a == b);
          1: t = (a != b);
          4: t = ($signed(a) < $signed(b));
          5: t = ($signed(a) >= $signed(b));
          6: t = (a < b);
          7: t = (a >= b);
          default: t = 0;
        endcase
        if (t) npc = m_pc + ib;
      end
      7'h03: begin
        addr = a + ii;
        wb = int'({addr[9:2], 2'b00});
        hb = wb + (addr[1] ? 2 : 0);
        wr = 1;
        case (f3)
          0: val = {{24{m_dmem[addr[9:0]][7]}}, m_dmem[addr[9:0]]};
          1: val = {{16{m_dmem[hb+1][7]}}, m_dmem[hb+1], m_dmem[hb]};
          2: val = {m_dmem[wb+3], m_dmem[wb+2], m_dmem[wb+1], m_dmem[wb]};
          4: val = {24'b0, m_dmem[addr[9:0]]};
          5: val = {16'b0, m_dmem[hb+1], m_dmem[hb]};
          default: wr = 0;
        endcase
      end
      7'h23: begin
        addr = a + is;
        wb = int'({addr[9:2], 2'b00});
        hb = wb + (addr[1] ? 2 : 0);
        case (f3)
          0: begin m_dmem[addr[9:0]] = b[7:0]; m_dv[addr[9:0]] = 1; end
          1: for (int k = 0; k < 2; k++) begin m_dmem[hb+k] = b[k*8 +: 8]; m_dv[hb+k] = 1; end
          2: for (int k = 0; k < 4; k++) begin m_dmem[wb+k] = b[k*8 +: 8]; m_dv[wb+k] = 1; end
          default: ;
        endcase
      end
      7'h13, 7'h33: begin
        if (op == 7'h13) b = ii;
        wr = 1;
        case (f3)
          0: val = (op == 7'h33 && f7 == 7'h20) ? a - b : a + b;
          1: val = a << b[4:0];
          2: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3: val = (a < b) ? 32'd1 : 32'd0;
          4: val = a ^ b;
          5: val = (f7 == 7'h20) ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
          6: val = a | b;
          default: val = a & b;
        endcase
        if (op == 7'h33 && !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)))) wr = 0;
        if (op == 7'h13 && f3 == 1 && f7 != 0) wr = 0;
        if (op == 7'h13 && f3 == 5 && f7 != 0 && f7 != 7'h20) wr = 0;
      end
      default: ;
    endcase
    if (wr && rd != 0) m_regs[rd] = val;
    m_pc = npc;
  endtask

  always @(posedge clk) if (rst && chk_en) model_step();

  always @(negedge clk) begin
    if (rst && chk_en) begin
      check("pc", dut.pc, m_pc);
      for (int i = 1; i < 32; i++) check($sformatf("x%0d", i), dut.rf[i], m_regs[i]);
      for (int i = 0; i < 1024; i++)
        if (m_dv[i]) check($sformatf("dmem_byte_%0d", i), {24'b0, dut.dmem[i/4][(i%4)*8 +: 8]}, {24'b0, m_dmem[i]});
    end
  end

  // Last word is loaded through a wrapped, misaligned address to exercise the address decode.
  task automatic load_prog(input logic [31:0] prog [$]);
    @(negedge clk); #1;
    rst = 1'b0;
    model_reset();
    foreach (prog[i]) begin
      LoadProg_addr = 32'(i * 4);
      if (i == prog.size() - 1) LoadProg_addr = LoadProg_addr | 32'hFFFF_FC03;
      LoadProg_data = prog[i];
      m_imem[i] = prog[i];
      @(negedge clk); #1;
    end
    rst = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] dut_reg(input int i);
    return (i == 0) ? 32'd0 : dut.rf[i];
  endfunction

  localparam logic [31:0] HALT = 32'h0000006F;
  logic [31:0] p1 [$] = '{32'h00500093, 32'hFFD08113, 32'h002081B3, HALT};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Straight-line arithmetic.
    load_prog(p1);
    run(3);
    check("p1_x1", dut_reg(1), 32'd5);
    check("p1_x2", dut_reg(2), 32'd2);
    check("p1_x3", dut_reg(3), 32'd7);
    check("p1_pc", dut.pc, 32'd12);
    run(2);
    check("p1_halt_pc", dut.pc, 32'd12);

    // Countdown loop exits after seven instructions.
    load_prog('{32'h00300093, 32'hFFF08093, 32'hFE009EE3, HALT});
    run(6);
    check("loop_pc_c6", dut.pc, 32'd8);
    run(1);
    check("loop_pc_exit", dut.pc, 32'd12);
    check("loop_x1", dut_reg(1), 32'd0);

    // Loads and stores with lane selection, sign handling and misalignment.
    load_prog('{32'h123452B7, 32'h67828293, 32'h00502023, 32'h00000303,
                32'h00304383, 32'h00201403, 32'hF8000493, 32'h009002A3,
                32'h00500503, 32'h00504583, 32'h00301603, 32'h00102683, HALT});
    run(12);
    check("mem_x5", dut_reg(5), 32'h12345678);
    check("mem_dmem0", dut.dmem[0], 32'h12345678);
    check("mem_lb", dut_reg(6), 32'h00000078);
    check("mem_lbu", dut_reg(7), 32'h00000012);
    check("mem_lh", dut_reg(8), 32'h00001234);
    check("mem_lb_neg", dut_reg(10), 32'hFFFFFF80);
    check("mem_lbu_hi", dut_reg(11), 32'h00000080);
    check("mem_lh_misal", dut_reg(12), 32'h00001234);
    check("mem_lw_misal", dut_reg(13), 32'h12345678);
    check("mem_pc", dut.pc, 32'd48);

    // JAL then JALR back.
    load_prog('{32'h008000EF, HALT, 32'h00008067});
    run(1);
    check("jal_pc", dut.pc, 32'd8);
    check("jal_x1", dut_reg(1), 32'd4);
    run(1);
    check("jalr_pc", dut.pc, 32'd4);
    run(2);

    // x0 write, unknown encoding, ECALL: all leave registers alone.
    load_prog('{32'h00700013, 32'hFFFFFFFF, 32'h00000073, HALT});
    run(3);
    check("nop_x0", dut_reg(0), 32'd0);
    check("nop_pc", dut.pc, 32'd12);
    for (int i = 1; i < 32; i++) check($sformatf("nop_x%0d", i), dut_reg(i), 32'd0);

    // ALU mix, signed branch and AUIPC.
    load_prog('{32'hFF000093, 32'h4020D113, 32'h01C0D193, 32'h0030A233,
                32'h0030B2B3, 32'h40118333, 32'h0030C3B3, 32'h0030C463,
                32'h00100413, 32'h00001497, HALT});
    run(9);
    check("alu_srai", dut_reg(2), 32'hFFFFFFFC);
    check("alu_srli", dut_reg(3), 32'h0000000F);
    check("alu_slt", dut_reg(4), 32'd1);
    check("alu_sltu", dut_reg(5), 32'd0);
    check("alu_sub", dut_reg(6), 32'd31);
    check("alu_xor", dut_reg(7), 32'hFFFFFFFF);
    check("alu_blt_skip", dut_reg(8), 32'd0);
    check("alu_auipc", dut_reg(9), 32'h00001024);
    check("alu_pc", dut.pc, 32'd40);

    // Asynchronous reset mid-run, then re-execution.
    load_prog(p1);
    run(2);
    check("rst_pre_x2", dut_reg(2), 32'd2);
    LoadProg_addr = 32'd0;
    LoadProg_data = p1[0];
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_async_pc", dut.pc, 32'd0);
    check("rst_async_x1", dut_reg(1), 32'd0);
    check("rst_async_x2", dut_reg(2), 32'd0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b1;
    run(3);
    check("rerun_x3", dut_reg(3), 32'd7);
    check("rerun_pc", dut.pc, 32'd12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
